// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared open-drain CLK/DATA pair:
// clock inhibit, start request, device-clocked data/parity/stop, then ACK check.
// ckOe/dqOe are "pull low" enables for the pad tristates at the top level.
module ps2_tx #(
    parameter int INHIBIT = 840,     // ce ticks CLK is held low before the request
    parameter int TIMEOUT = 105000,  // ce ticks from CLK release to final ACK
    parameter int CW      = 17       // tick counter width, 2^CW > max(INHIBIT, TIMEOUT)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       tx,
    input  logic [7:0] d,
    input  logic       ckI,
    input  logic       dqI,
    output logic       ckOe,
    output logic       dqOe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITREL
    } state_t;

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // Pad synchronisers: bit 1 = CLK, bit 0 = DATA. They advance on ce so
    // that edge detection sees the same time base as the FSM.
    // ------------------------------------------------------------------
    logic [1:0] pad_in;
    logic [1:0] pad_sync;

    assign pad_in = {ckI, dqI};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-stage synchroniser; idles high like a released bus line.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else if (ce) begin
                    meta_reg <= pad_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign pad_sync[gi] = sync_reg;
        end
    endgenerate

    logic ck_sync;
    logic dq_sync;
    logic ck_prev_reg;
    logic ck_fall;

    assign ck_sync = pad_sync[1];
    assign dq_sync = pad_sync[0];

    // Previous synced CLK value, used to spot device-driven falling edges.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ck_prev_reg <= 1'b1;
        end else if (ce) begin
            ck_prev_reg <= ck_sync;
        end
    end

    assign ck_fall = ck_prev_reg & ~ck_sync;

    // ------------------------------------------------------------------
    // Transfer state machine
    // ------------------------------------------------------------------
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;      // inhibit timer, then frame timeout timer
    logic [3:0]    bitcnt_reg;   // falling edges consumed in SEND
    logic [9:0]    shift_reg;    // {stop, parity, data}, shifted out LSB first
    logic          ck_oe_reg;
    logic          dq_oe_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;
    logic          timed_out;

    // Timeout only matters once CLK has been released to the device.
    assign timed_out = (cnt_reg == TMO_LAST);

    // Single registered FSM: every output is a flop, all moves gated by ce.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= CNT_ZERO;
            bitcnt_reg <= 4'd0;
            shift_reg  <= 10'd0;
            ck_oe_reg  <= 1'b0;
            dq_oe_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else if (ce) begin
            // done/err are single-tick pulses.
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (tx) begin
                        // Odd parity: parity bit makes the total count of ones odd.
                        shift_reg <= {1'b1, ~^d, d};
                        cnt_reg   <= CNT_ZERO;
                        busy_reg  <= 1'b1;
                        ck_oe_reg <= 1'b1;
                        state_reg <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt_reg == INH_LAST) begin
                        // Start bit: DATA low while CLK is still held.
                        dq_oe_reg <= 1'b1;
                        cnt_reg   <= CNT_ZERO;
                        state_reg <= S_REQ;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                S_REQ: begin
                    // Release CLK; the device now owns the clock. The timeout
                    // budget starts counting on this tick.
                    ck_oe_reg  <= 1'b0;
                    bitcnt_reg <= 4'd0;
                    cnt_reg    <= cnt_reg + CNT_ONE;
                    state_reg  <= S_SEND;
                end

                S_SEND: begin
                    if (timed_out) begin
                        ck_oe_reg <= 1'b0;
                        dq_oe_reg <= 1'b0;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                        if (ck_fall) begin
                            // Open drain: pull low for a 0, release for a 1.
                            dq_oe_reg  <= ~shift_reg[0];
                            shift_reg  <= {1'b0, shift_reg[9:1]};
                            bitcnt_reg <= bitcnt_reg + 4'd1;
                            if (bitcnt_reg == 4'd9) begin
                                state_reg <= S_ACK;
                            end
                        end
                    end
                end

                S_ACK: begin
                    // Timeout takes priority so a coincident ACK failure
                    // still yields only one err pulse.
                    if (timed_out) begin
                        ck_oe_reg <= 1'b0;
                        dq_oe_reg <= 1'b0;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                        if (ck_fall) begin
                            if (!dq_sync) begin
                                state_reg <= S_WAITREL;
                            end else begin
                                ck_oe_reg <= 1'b0;
                                dq_oe_reg <= 1'b0;
                                err_reg   <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                end

                S_WAITREL: begin
                    if (timed_out) begin
                        ck_oe_reg <= 1'b0;
                        dq_oe_reg <= 1'b0;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                        // Device has let go of both lines: the frame is complete.
                        if (ck_sync && dq_sync) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end
                end

                default: begin
                    ck_oe_reg <= 1'b0;
                    dq_oe_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ckOe = ck_oe_reg;
    assign dqOe = dq_oe_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural keyboard drives CLK/DATA, records the bits it
// sees on the wire before each falling edge, and optionally ACKs on edge 11.
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int TMO = 400;
    localparam int H   = 8;   // device half-period in ce ticks

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce    = 1'b0;
    logic       tx    = 1'b0;
    logic [7:0] d     = 8'h00;
    wire        ckI;
    wire        dqI;
    logic       ckOe, dqOe, busy, done, err;

    // Device model state
    bit         dev_arm  = 1'b0;
    bit         dev_on   = 1'b0;
    bit         dev_ack  = 1'b1;
    logic       dev_ck   = 1'b1;
    logic       dev_dq   = 1'b1;
    int         dev_t    = 0;
    int         dev_edges = 0;
    logic [10:0] wire_bits = '0;

    int checks   = 0;
    int failures = 0;

    ps2_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .CW(17)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .tx    (tx),
        .d     (d),
        .ckI   (ckI),
        .dqI   (dqI),
        .ckOe  (ckOe),
        .dqOe  (dqOe),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // Open-drain wire: low if either side pulls.
    assign ckI = dev_ck & ~ckOe;
    assign dqI = dev_dq & ~dqOe;

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One ce tick: ce high for one clock, then one idle clock; sample #1 after.
    task automatic ce_tick();
        ce = 1'b1;
        @(posedge clock);
        #1;
        ce = 1'b0;
        tx = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Advance the keyboard model by one ce tick (called before ce_tick).
    task automatic dev_step();
        if (dev_arm && !dev_on && busy && !ckOe && dqOe) begin
            dev_on  = 1'b1;
            dev_arm = 1'b0;
            dev_t   = 0;
        end
        if (dev_on) begin
            if (dev_edges < 11 && (dev_t % (2*H)) == H-1)
                wire_bits[dev_edges] = dev_dq & ~dqOe;
            if (dev_edges < 11 && (dev_t % (2*H)) == H) begin
                dev_ck = 1'b0;
                dev_edges++;
                if (dev_edges == 11 && dev_ack) dev_dq = 1'b0;
            end
            if (dev_t > 0 && (dev_t % (2*H)) == 0) dev_ck = 1'b1;
            if (dev_t == 23*H) begin
                dev_dq = 1'b1;
                dev_on = 1'b0;
            end
            dev_t++;
        end
    endtask

    task automatic dev_reset(input bit arm, input bit ack);
        dev_arm   = arm;
        dev_on    = 1'b0;
        dev_ack   = ack;
        dev_ck    = 1'b1;
        dev_dq    = 1'b1;
        dev_t     = 0;
        dev_edges = 0;
        wire_bits = '0;
    endtask

    // Run one full frame; optionally pulse tx with 0x55 once the device has
    // produced inj_edge falling edges.
    task automatic run_frame(input logic [7:0] dv, input bit ack, input int inj_edge,
                             output logic [10:0] bits, output int n_done, output int n_err,
                             output int n_both, output int n_cklow, output int n_busy_after,
                             output bit ended);
        bit injected;
        injected = 1'b0;
        n_done = 0; n_err = 0; n_both = 0; n_cklow = 0; n_busy_after = 0;
        ended = 1'b0;
        dev_reset(1'b1, ack);
        d  = dv;
        tx = 1'b1;
        dev_step();
        ce_tick();
        if (ckOe) n_cklow++;
        for (int i = 0; i < 3000 && !ended; i++) begin
            if (inj_edge > 0 && !injected && dev_edges == inj_edge) begin
                d  = 8'h55;
                tx = 1'b1;
                injected = 1'b1;
            end
            dev_step();
            ce_tick();
            if (ckOe) n_cklow++;
            if (done) n_done++;
            if (err) n_err++;
            if (done && err) n_both++;
            if (!busy) ended = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            dev_step();
            ce_tick();
            if (done) n_done++;
            if (err) n_err++;
            if (busy) n_busy_after++;
        end
        bits = wire_bits;
    endtask

    typedef struct {
        logic [7:0]  d;
        bit          ack;
        int          inj;
        logic [10:0] exp_bits;   // bit k = wire before edge k+1: start, d0..d7, parity, stop
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [10:0] bits;
        int n_done, n_err, n_both, n_cklow, n_busy_after, n;
        bit ended;

        vecs[0] = '{8'hED, 1'b1, 0, 11'h7DA, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 0, 11'h402, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 0, 11'h600, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 0, 11'h7FE, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 0, 11'h500, 1, 0};
        vecs[5] = '{8'h5A, 1'b0, 0, 11'h6B4, 0, 1};  // no ACK on edge 11
        vecs[6] = '{8'hED, 1'b1, 3, 11'h7DA, 1, 0};  // tx 0x55 while busy

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ckOe", ckOe, 0);
        chk("reset_dqOe", dqOe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done_err", {done, err}, 0);
        reset = 1'b1;
        repeat (3) ce_tick();

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].d, vecs[v].ack, vecs[v].inj, bits, n_done, n_err,
                      n_both, n_cklow, n_busy_after, ended);
            $display("frame %0d d=0x%02h wire=0x%03h done=%0d err=%0d cklow=%0d",
                     v, vecs[v].d, bits, n_done, n_err, n_cklow);
            chk($sformatf("v%0d_wire_bits", v), bits, vecs[v].exp_bits);
            chk($sformatf("v%0d_done_count", v), n_done, vecs[v].exp_done);
            chk($sformatf("v%0d_err_count", v), n_err, vecs[v].exp_err);
            chk($sformatf("v%0d_done_err_overlap", v), n_both, 0);
            chk($sformatf("v%0d_ended", v), ended, 1);
            chk($sformatf("v%0d_inhibit_long", v), (n_cklow >= INH && n_cklow <= INH + 1), 1);
            chk($sformatf("v%0d_lines_released", v), {ckOe, dqOe, busy}, 0);
            chk($sformatf("v%0d_busy_after", v), n_busy_after, 0);
        end

        // Timeout: device never clocks after CLK release
        dev_reset(1'b0, 1'b1);
        d  = 8'h3C;
        tx = 1'b1;
        ce_tick();
        n = 0;
        while (!dqOe && n < 200) begin
            ce_tick();
            n++;
        end
        chk("tmo_start_bit", dqOe, 1);
        n = 0; n_done = 0;
        while (!err && n < 2*TMO) begin
            ce_tick();
            n++;
            if (done) n_done++;
        end
        $display("timeout err after %0d ticks", n);
        chk("tmo_latency", n, TMO);
        chk("tmo_lines", {ckOe, dqOe, busy}, 0);
        chk("tmo_no_done", n_done, 0);
        ce_tick();
        chk("tmo_err_one_tick", err, 0);
        repeat (3) ce_tick();

        // Reset during INHIBIT, with ce low
        d  = 8'h00;
        tx = 1'b1;
        ce_tick();
        repeat (5) ce_tick();
        chk("inh_pre_ckOe", ckOe, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        $display("reset in inhibit ckOe=%0d busy=%0d", ckOe, busy);
        chk("inh_rst_ckOe", ckOe, 0);
        chk("inh_rst_busy", busy, 0);
        repeat (3) ce_tick();

        // Reset after edge 4 of a 0x00 frame (d3=0 so DATA is being pulled)
        dev_reset(1'b1, 1'b1);
        d  = 8'h00;
        tx = 1'b1;
        dev_step();
        ce_tick();
        n = 0;
        while (dev_edges < 4 && n < 1000) begin
            dev_step();
            ce_tick();
            n++;
        end
        repeat (4) begin
            dev_step();
            ce_tick();
        end
        chk("mid_pre_dqOe", dqOe, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        $display("reset mid-frame ckOe=%0d dqOe=%0d busy=%0d", ckOe, dqOe, busy);
        chk("mid_rst_ckOe", ckOe, 0);
        chk("mid_rst_dqOe", dqOe, 0);
        chk("mid_rst_busy", busy, 0);
        dev_reset(1'b0, 1'b1);
        reset = 1'b1;
        repeat (3) ce_tick();
        run_frame(8'hFF, 1'b1, 0, bits, n_done, n_err, n_both, n_cklow, n_busy_after, ended);
        $display("frame after reset d=0xff wire=0x%03h done=%0d err=%0d", bits, n_done, n_err);
        chk("post_rst_wire", bits, 11'h7FE);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_err", n_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the core to the keyboard over the same keybCk/keybDQ open-drain pair that the existing ps2 receiver listens on.
- Implements the full host request sequence: clock inhibit, start request, device-clocked data, parity and stop bits, then device ACK check.
- Sits at the top level beside the ps2 receiver. Its `ckOe` and `dqOe` outputs are combined with the pad tristates.

Parameters:
- INHIBIT, 840: ce ticks that CLK is held low before the request. 120 µs at 7 MHz.
- TIMEOUT, 105000: ce ticks allowed from CLK release to final ACK before an error is flagged. 15 ms at 7 MHz.
- CW, 17: width of the shared tick counter. Must satisfy 2^CW > max(INHIBIT, TIMEOUT).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-low reset.
- ce, in, 1: clock enable. All state advances only when ce=1. Driven by the 7 MHz enable.
- tx, in, 1: start strobe. Sampled when ce=1 and busy=0.
- d, in, 8: byte to send. Latched when tx is accepted.
- ckI, in, 1: PS/2 CLK pad input.
- dqI, in, 1: PS/2 DATA pad input.
- ckOe, out, 1: 1 = pull CLK low, 0 = release.
- dqOe, out, 1: 1 = pull DATA low, 0 = release.
- busy, out, 1: transfer in progress.
- done, out, 1: one-ce-tick pulse; the frame ended with ACK.
- err, out, 1: one-ce-tick pulse; the frame ended with timeout or missing ACK.

Behaviour:
- Reset (reset=0 at a clock edge, regardless of ce): state=IDLE, ckOe=0, dqOe=0, busy=0, done=0, err=0, counter=0, bit count=0. A reset mid-frame releases both lines on the next clock.
- Input synchronisation: ckI and dqI each pass through a 2-FF synchroniser clocked on ce. A CLK falling edge = previous synced value 1 and current 0.
- Shift register: 10 bits = {stop=1, parity, d[7:0]}. Parity is odd, i.e. ~^d.
- IDLE:
  - busy=0.
  - On tx=1: latch the shift register, clear the counter, busy=1, ckOe=1, go to INHIBIT.
  - tx while busy is ignored.
- INHIBIT:
  - Counter increments each ce.
  - At INHIBIT-1: dqOe=1 (start bit), clear the counter, go to REQ.
- REQ: one ce tick later, ckOe=0 (CLK released), go to SEND with bit count=0. The TIMEOUT counter runs from here until the ACK state.
- SEND, on each synced CLK falling edge:
  - dqOe = ~shift[0], shift right, increment bit count.
  - Edges 1–8 put out d[0]..d[7] (LSB first). Edge 9 puts out parity. Edge 10 puts out stop (dqOe=0).
  - After edge 10 go to ACK.
- ACK:
  - On the next CLK falling edge (edge 11), sample synced DATA.
  - DATA=0: go to WAITREL.
  - DATA=1: err pulse, go to IDLE.
- WAITREL: wait until synced CLK=1 and DATA=1, then done pulse and go to IDLE.
- Timeout:
  - Applies in SEND, ACK and WAITREL.
  - When the counter reaches TIMEOUT-1: ckOe=0, dqOe=0, err pulse, go to IDLE.
  - If timeout and ACK-fail fall on the same tick, only one err pulse is produced.
- Pulses and the next transfer:
  - done and err last exactly one ce tick and are never asserted together.
  - busy drops on the same tick as the done/err pulse.
  - A new tx is accepted on the following ce tick.
- While busy, the receiver must ignore traffic. The top level gates the receiver's kstb with ~busy; this block provides nothing further for that.

Test Plan:
- Send d=0xED with a device model clocking at 12 kHz and ACKing. Required:
  - CLK held low for ≥840 ticks.
  - DATA bits on the wire: 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device sees an ACK low; one done pulse; no err; busy low afterwards.
- Parity checks: send d=0x01 → parity bit 0; send d=0x00 and d=0xFF → parity bit 1.
- Device model never clocks after the CLK release. Required: err pulse exactly TIMEOUT ticks after REQ; ckOe=0 and dqOe=0; busy=0.
- Device clocks 11 edges but leaves DATA high on edge 11. Required: err pulse, no done, both lines released.
- Assert reset=0 after edge 4 of a frame. Required: ckOe=0, dqOe=0, busy=0 on the next clock. A subsequent tx of 0xFF completes with done.
- Pulse tx with d=0x55 while busy during a 0xED frame. Required: the wire shows only the 0xED bits; one done pulse; 0x55 is never sent.
